// File: rtl/bsr_shift_seq.sv
// bsr_shift_seq: request/response sequencer in front of a logical-right barrel
// shifter. It adds arithmetic right shifts by complementing the operand before
// the shift and the result after it. It adds rotate-right by running two shifter
// passes and OR-ing the partial results.
module bsr_shift_seq #(
   parameter int unsigned DW = 32,
   parameter int unsigned SW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic [1:0]    REQ_OP,
   input  logic [SW-1:0] REQ_AMT,
   input  logic [DW-1:0] REQ_DATA,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic [DW-1:0] RSP_DATA,
   output logic          RSP_ERR,
   output logic [SW-1:0] BS_AMT,
   output logic [DW-1:0] BS_DIN,
   input  logic [DW-1:0] BS_DOUT
);

   // DW expressed one bit wider than the shift amount, so DW - amt is exact.
   localparam logic [SW:0] DW_EXT = (SW+1)'(DW);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PASS1 = 2'b01,
      ST_PASS2 = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_ROR = 2'b10,
      OP_ILL = 2'b11
   } op_t;

   state_t        state_q;
   op_t           op_q;
   logic [SW-1:0] amt_q;
   logic [DW-1:0] data_q;
   logic [DW-1:0] acc_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_err_q;
   logic          rsp_valid_q;

   logic          sra_neg;
   logic [DW-1:0] pass1_res_d;
   logic [DW-1:0] pass2_res_d;
   logic [SW-1:0] bs_amt_d;
   logic [DW-1:0] bs_din_d;

   // Bit reversal. It turns the shifter's right shift into a left shift for
   // the second rotate pass.
   function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] x);
      logic [DW-1:0] r;
      for (int unsigned i = 0; i < DW; i++) begin
         r[i] = x[DW-1-i];
      end
      return r;
   endfunction

   // Drive the shifter and form the pass results from its combinational output.
   always_comb begin
      bs_amt_d    = '0;
      bs_din_d    = '0;
      sra_neg     = (op_q == OP_SRA) && data_q[DW-1];
      pass1_res_d = sra_neg ? ~BS_DOUT : BS_DOUT;
      pass2_res_d = acc_q | bitrev(BS_DOUT);
      case (state_q)
         ST_PASS1: begin
            bs_amt_d = amt_q;
            bs_din_d = sra_neg ? ~data_q : data_q;
         end
         ST_PASS2: begin
            bs_amt_d = SW'(DW_EXT - {1'b0, amt_q});
            bs_din_d = bitrev(data_q);
         end
         default: begin
            bs_amt_d = '0;
            bs_din_d = '0;
         end
      endcase
   end

   assign BS_AMT    = bs_amt_d;
   assign BS_DIN    = bs_din_d;
   assign REQ_READY = (state_q == ST_IDLE) && !RST;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_ERR   = rsp_err_q;

   // Sequencer: accept, one or two shifter passes, then hold the response.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_SRL;
         amt_q       <= '0;
         data_q      <= '0;
         acc_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (REQ_VALID) begin
                  op_q   <= op_t'(REQ_OP);
                  amt_q  <= REQ_AMT;
                  data_q <= REQ_DATA;
                  if (REQ_OP == OP_ILL) begin
                     rsp_data_q  <= REQ_DATA;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     rsp_err_q <= 1'b0;
                     state_q   <= ST_PASS1;
                  end
               end
            end
            ST_PASS1: begin
               if (op_q == OP_ROR) begin
                  acc_q <= BS_DOUT;
                  if (amt_q == '0) begin
                     rsp_data_q  <= BS_DOUT;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     state_q <= ST_PASS2;
                  end
               end else begin
                  rsp_data_q  <= pass1_res_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_PASS2: begin
               rsp_data_q  <= pass2_res_d;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (RSP_READY) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsr_shift_seq.sv
// Testbench for bsr_shift_seq. It models the external logical-right barrel
// shifter and checks directed and random operations against a reference model
// written with plain shift and rotate arithmetic.
module tb_bsr_shift_seq;

   localparam int unsigned DW = 32;
   localparam int unsigned SW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [SW-1:0] req_amt;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [SW-1:0] bs_amt;
   logic [DW-1:0] bs_din;
   logic [DW-1:0] bs_dout;

   int tests = 0;
   int fails = 0;

   bsr_shift_seq #(.DW(DW), .SW(SW)) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ_VALID (req_valid),
      .REQ_READY (req_ready),
      .REQ_OP    (req_op),
      .REQ_AMT   (req_amt),
      .REQ_DATA  (req_data),
      .RSP_VALID (rsp_valid),
      .RSP_READY (rsp_ready),
      .RSP_DATA  (rsp_data),
      .RSP_ERR   (rsp_err),
      .BS_AMT    (bs_amt),
      .BS_DIN    (bs_din),
      .BS_DOUT   (bs_dout)
   );

   // External combinational logical-right barrel shifter.
   assign bs_dout = bs_din >> bs_amt;

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {err, data} from the operation definitions.
   function automatic logic [32:0] model(input logic [1:0] op, input logic [4:0] amt,
                                         input logic [31:0] d);
      logic [63:0] dd;
      case (op)
         2'd0: return {1'b0, d >> amt};
         2'd1: return {1'b0, 32'($signed(d) >>> amt)};
         2'd2: begin
            dd = {d, d} >> amt;
            return {1'b0, dd[31:0]};
         end
         default: return {1'b1, d};
      endcase
   endfunction

   // One complete transaction with optional response backpressure.
   task automatic do_op(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d,
                        input int hold, input string tag,
                        output logic [4:0] p1_amt, output logic [31:0] p1_din,
                        output logic [4:0] p2_amt, output logic [31:0] got);
      logic [32:0] exp;
      int          n;
      int          exp_lat;
      exp     = model(op, amt, d);
      exp_lat = (op == 2'd3) ? 1 : ((op == 2'd2 && amt != 5'd0) ? 3 : 2);
      check({tag, ":req_ready_idle"}, 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_amt   = amt;
      req_data  = d;
      tick();
      n      = 1;
      p1_amt = bs_amt;
      p1_din = bs_din;
      p2_amt = '0;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_amt   = 5'($urandom);
      req_data  = $urandom;
      check({tag, ":req_ready_busy"}, 64'(req_ready), 64'(0));
      while (!rsp_valid && n < 8) begin
         tick();
         n++;
         if (n == 2) p2_amt = bs_amt;
      end
      got = rsp_data;
      check({tag, ":latency"}, 64'(n), 64'(exp_lat));
      check({tag, ":rsp_data"}, 64'(rsp_data), 64'(exp[31:0]));
      check({tag, ":rsp_err"}, 64'(rsp_err), 64'(exp[32]));
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_op    = 2'($urandom_range(0, 2));
         req_amt   = 5'($urandom);
         req_data  = $urandom;
         tick();
         check({tag, ":hold_valid"}, 64'(rsp_valid), 64'(1));
         check({tag, ":hold_data"}, 64'(rsp_data), 64'(exp[31:0]));
         check({tag, ":hold_req_ready"}, 64'(req_ready), 64'(0));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, ":done_valid"}, 64'(rsp_valid), 64'(0));
      check({tag, ":done_req_ready"}, 64'(req_ready), 64'(1));
   endtask

   initial begin
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] d1;
      logic [31:0] got;
      logic [1:0]  r_op;
      logic [4:0]  r_amt;
      logic [31:0] r_data;
      int          r_hold;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_amt   = '0;
      req_data  = '0;
      rsp_ready = 1'b0;

      // Reset state.
      #12;
      check("rst:rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst:rsp_data", 64'(rsp_data), 64'(0));
      check("rst:rsp_err", 64'(rsp_err), 64'(0));
      check("rst:bs_amt", 64'(bs_amt), 64'(0));
      check("rst:bs_din", 64'(bs_din), 64'(0));
      tick();
      rst = 1'b0;
      #1;
      check("rst:req_ready_after", 64'(req_ready), 64'(1));

      // SRL.
      do_op(2'd0, 5'd4, 32'h8000_0000, 0, "srl", a1, d1, a2, got);
      check("srl:bs_amt", 64'(a1), 64'(4));
      check("srl:bs_din", 64'(d1), 64'h8000_0000);
      check("srl:result", 64'(got), 64'h0800_0000);

      // SRA on a negative and a positive operand.
      do_op(2'd1, 5'd4, 32'h8000_0010, 0, "sra_neg", a1, d1, a2, got);
      check("sra_neg:bs_din", 64'(d1), 64'h7FFF_FFEF);
      check("sra_neg:result", 64'(got), 64'hF800_0001);
      do_op(2'd1, 5'd31, 32'h4000_0000, 0, "sra_pos", a1, d1, a2, got);
      check("sra_pos:result", 64'(got), 64'h0000_0000);

      // ROR with two passes and with a single pass.
      do_op(2'd2, 5'd8, 32'h1234_5678, 0, "ror8", a1, d1, a2, got);
      check("ror8:pass1_amt", 64'(a1), 64'(8));
      check("ror8:pass2_amt", 64'(a2), 64'(24));
      check("ror8:result", 64'(got), 64'h7812_3456);
      do_op(2'd2, 5'd0, 32'h1234_5678, 0, "ror0", a1, d1, a2, got);
      check("ror0:pass1_amt", 64'(a1), 64'(0));
      check("ror0:result", 64'(got), 64'h1234_5678);

      // Illegal op leaves the shifter idle.
      do_op(2'd3, 5'd7, 32'hDEAD_BEEF, 0, "illegal", a1, d1, a2, got);
      check("illegal:bs_din", 64'(d1), 64'(0));
      check("illegal:result", 64'(got), 64'hDEAD_BEEF);

      // Backpressure with new requests arriving while busy.
      do_op(2'd0, 5'd1, 32'hA5A5_A5A5, 5, "bp", a1, d1, a2, got);

      // Reset during the second rotate pass.
      req_valid = 1'b1;
      req_op    = 2'd2;
      req_amt   = 5'd8;
      req_data  = 32'h1234_5678;
      tick();
      req_valid = 1'b0;
      tick();
      check("rst_mid:pass2_amt", 64'(bs_amt), 64'(24));
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid:rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_mid:bs_din", 64'(bs_din), 64'(0));
      check("rst_mid:bs_amt", 64'(bs_amt), 64'(0));
      tick();
      rst = 1'b0;
      tick();
      check("rst_mid:no_rsp", 64'(rsp_valid), 64'(0));
      check("rst_mid:req_ready", 64'(req_ready), 64'(1));
      do_op(2'd0, 5'd8, 32'hF0F0_F0F0, 0, "post_rst", a1, d1, a2, got);
      check("post_rst:result", 64'(got), 64'h00F0_F0F0);

      // Random operations against the reference model.
      for (int k = 0; k < 60; k++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_amt  = 5'($urandom);
         r_data = $urandom;
         r_hold = $urandom_range(0, 2);
         do_op(r_op, r_amt, r_data, r_hold, $sformatf("rand%0d", k), a1, d1, a2, got);
         if (r_op == 2'd2 && r_amt != 5'd0) begin
            check($sformatf("rand%0d:pass2_amt", k), 64'(a2), 64'(32 - int'(r_amt)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
